stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/sw_debounce.sv | 47 ++++
 rtl/stopwatch_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - stopwatch state encodings and debounce counter sizing
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } sw_state_e;

  localparam int unsigned DEB_CYCLES_MAX = 1 << 20;
  localparam int          DEB_CNT_W      = $clog2(DEB_CYCLES_MAX);

  function automatic logic state_runs(sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - 2-flop synchronizer, stability debouncer and rising-edge press pulse
module sw_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk0,
  input  logic rst,
  input  logic sw,
  output logic press
);

  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);
  localparam logic [DEB_CNT_W-1:0] CNT_ONE  = DEB_CNT_W'(1);

  logic                 s1;
  logic                 s2;
  logic                 db;
  logic                 db_q;
  logic [DEB_CNT_W-1:0] cnt;

  always_ff @(posedge clk0) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= sw;
      s2   <= s1;
      db_q <= db;
      // Any agreement restarts the stability window, so short glitches never accumulate.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign press = db & ~db_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch start/stop/clear/lap controller
// Optional lap feature enabled by defining STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic [1:0] sw,
  output logic       run,
  output logic       clr,
  output logic       lap_hold,
  output logic [1:0] state
);

  logic [1:0] press;
  sw_state_e  state_q;
  sw_state_e  state_d;
  logic       clr_d;

  for (genvar i = 0; i < 2; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk0 (clk0),
      .rst  (rst),
      .sw   (sw[i]),
      .press(press[i])
    );
  end

  // press[0] always wins; press[1] is only looked at when press[0] is idle.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press[0])      state_d = ST_RUN;
        else if (press[1]) clr_d   = 1'b1;
      end
      ST_RUN: begin
        if (press[0])      state_d = ST_PAUSE;
`ifdef STOPWATCH_CTRL_LAP_EN
        else if (press[1]) state_d = ST_LAP;
`endif
      end
`ifdef STOPWATCH_CTRL_LAP_EN
      ST_LAP: begin
        if (press[0])      state_d = ST_PAUSE;
        else if (press[1]) state_d = ST_RUN;
      end
`endif
      ST_PAUSE: begin
        if (press[0]) begin
          state_d = ST_RUN;
        end else if (press[1]) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      run      <= 1'b0;
      clr      <= 1'b0;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_hold <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      run      <= state_runs(state_d);
      clr      <= clr_d;
`ifdef STOPWATCH_CTRL_LAP_EN
      lap_hold <= (state_d == ST_LAP);
`endif
    end
  end

`ifndef STOPWATCH_CTRL_LAP_EN
  assign lap_hold = 1'b0;
`endif

  assign state = state_q;

endmodule
